// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// One shift-add or restoring-divide step per cycle; stalls the pipe until the result is ready.
module ex_muldiv_sequencer #(
    parameter int XLEN         = 32,
    parameter bit SPECIAL_FAST = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_funct3;
    logic [XLEN-1:0]     r_b;
    logic                r_neg;
    logic [4:0]          r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_result;

    logic                w_issue;
    logic                w_sgn1, w_sgn2, w_neg1, w_neg2;
    logic [XLEN-1:0]     w_abs1, w_abs2;
    logic                w_op2_zero, w_ovf, w_fast, w_neg_flag;
    logic [XLEN-1:0]     w_fast_res;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_shift;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo, w_rem, w_fix_res;

    // Operand conditioning at issue: the loop always works on magnitudes
    assign w_issue    = (r_state == S_IDLE) && start && !flush;
    assign w_sgn1     = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign w_sgn2     = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign w_neg1     = w_sgn1 && op1[XLEN-1];
    assign w_neg2     = w_sgn2 && op2[XLEN-1];
    assign w_abs1     = w_neg1 ? ({XLEN{1'b0}} - op1) : op1;
    assign w_abs2     = w_neg2 ? ({XLEN{1'b0}} - op2) : op2;
    assign w_op2_zero = (op2 == {XLEN{1'b0}});
    assign w_ovf      = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                        (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == {XLEN{1'b1}});
    assign w_fast     = SPECIAL_FAST && funct3[2] && (w_op2_zero || w_ovf);
    assign w_fast_res = w_op2_zero ? (funct3[1] ? op1 : {XLEN{1'b1}})
                                   : (funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}});

    // A zero divisor must keep the all-ones quotient even for a negative dividend
    always_comb begin
        w_neg_flag = 1'b0;
        if (!funct3[2])
            w_neg_flag = w_neg1 ^ w_neg2;
        else if (funct3[1])
            w_neg_flag = w_neg1;
        else
            w_neg_flag = (w_neg1 ^ w_neg2) && !w_op2_zero;
    end

    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_diff  = w_div_shift[XLEN-1:0] - r_b;
    assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_div_ge};

    assign w_prod = r_neg ? ({(2*XLEN){1'b0}} - r_acc) : r_acc;
    assign w_quo  = r_neg ? ({XLEN{1'b0}} - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    assign w_rem  = r_neg ? ({XLEN{1'b0}} - r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = w_prod[XLEN-1:0];
        case (r_funct3)
            3'd0:             w_fix_res = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_fix_res = w_quo;
            default:          w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_issue) w_next = w_fast ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_funct3 <= 3'd0;
            r_b      <= {XLEN{1'b0}};
            r_neg    <= 1'b0;
            r_cnt    <= 5'd0;
            r_acc    <= {(2*XLEN){1'b0}};
            r_result <= {XLEN{1'b0}};
        end else if (w_issue) begin
            r_funct3 <= funct3;
            r_b      <= w_abs2;
            r_neg    <= w_neg_flag;
            r_cnt    <= 5'd0;
            r_acc    <= {{XLEN{1'b0}}, w_abs1};
            if (w_fast)
                r_result <= w_fast_res;
        end else if (r_state == S_CALC && !flush) begin
            r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 5'd1;
        end else if (r_state == S_FIX && !flush) begin
            r_result <= w_fix_res;
        end
    end

    assign stall  = resetn && !flush && (w_issue || r_state == S_CALC || r_state == S_FIX);
    assign done   = (r_state == S_DONE) && !flush;
    assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer against an arithmetic RV32M reference.
module tb_ex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op1, op2;
    logic        flush;
    logic        stall, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    ex_muldiv_sequencer #(.XLEN(32), .SPECIAL_FAST(1'b1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .funct3(funct3),
        .op1(op1), .op2(op2), .flush(flush),
        .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0 || ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issues one op at a negedge and follows it until done; lat=-1 on timeout.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int scnt);
        lat  = -1;
        res  = 32'd0;
        scnt = 0;
        @(negedge clk);
        funct3 = f; op1 = a; op2 = b; start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (n > 0) begin
                @(negedge clk);
                start = 1'b0; funct3 = 3'($urandom); op1 = $urandom; op2 = $urandom;
            end
            #1;
            if (stall) scnt++;
            if (done) begin
                lat = n;
                res = result;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b1; flush = 1'b0; funct3 = 3'd0; op1 = 32'd3; op2 = 32'd4;
        #12;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        @(negedge clk);
        start = 1'b0; resetn = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: stall=%b done=%b want 0/0", stall, done);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  tf [15] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd0};
        logic [31:0] ta [15] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000,
                                 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h12345678};
        logic [31:0] tb [15] = '{32'hFFFFFFFA, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd0, 32'd0, 32'h9ABCDEF0};
        int lat, scnt, elat;
        logic [31:0] res, exp;
        for (int i = 0; i < 15; i++) begin
            exp  = ref_model(tf[i], ta[i], tb[i]);
            elat = ref_lat(tf[i], ta[i], tb[i]);
            run_op(tf[i], ta[i], tb[i], lat, res, scnt);
            checks++; if (lat != elat) begin errors++; $display("FAIL dir%0d_latency f=%0d: got %0d want %0d", i, tf[i], lat, elat); end
            checks++; if (res !== exp) begin errors++; $display("FAIL dir%0d_result f=%0d a=%h b=%h: got %h want %h", i, tf[i], ta[i], tb[i], res, exp); end
            checks++; if (scnt != elat) begin errors++; $display("FAIL dir%0d_stall_cycles: got %0d want %0d", i, scnt, elat); end
        end
    endtask

    task automatic test_random();
        int lat, scnt, elat;
        logic [31:0] res, exp, a, b;
        logic [2:0] f;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            exp  = ref_model(f, a, b);
            elat = ref_lat(f, a, b);
            run_op(f, a, b, lat, res, scnt);
            checks++; if (lat != elat || res !== exp || scnt != elat) begin
                errors++;
                $display("FAIL rnd%0d f=%0d a=%h b=%h: got res=%h lat=%0d stall=%0d want res=%h lat=%0d",
                         i, f, a, b, res, lat, scnt, exp, elat);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev, res;
        int lat, scnt, seen;
        prev = result;
        @(negedge clk);
        funct3 = 3'd5; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_issue_stall: got %b want 1", stall); end
        seen = 0;
        for (int n = 1; n < 10; n++) begin
            @(negedge clk); start = 1'b0; #1;
            if (done || !stall) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_pre_calc: %0d bad cycles want 0", seen); end
        @(negedge clk); flush = 1'b1; #1;
        checks++; if (stall !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush_same_cycle: stall=%b done=%b want 0/0", stall, done);
        end
        @(negedge clk); flush = 1'b0; #1;
        checks++; if (stall !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush_idle: stall=%b done=%b want 0/0", stall, done);
        end
        checks++; if (result !== prev) begin errors++; $display("FAIL flush_result_hold: got %h want %h", result, prev); end
        run_op(3'd5, 32'd1000, 32'd7, lat, res, scnt);
        checks++; if (lat != 34 || res !== 32'd142) begin
            errors++; $display("FAIL flush_restart: got lat=%0d res=%h want 34/%h", lat, res, 32'd142);
        end
        prev = result;
        @(negedge clk);
        funct3 = 3'd4; op1 = 32'd5; op2 = 32'd0; start = 1'b1; flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall: got %b want 0", stall); end
        @(negedge clk); start = 1'b0; flush = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            #1; if (done || stall) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0 || result !== prev) begin
            errors++; $display("FAIL flush_start_dropped: bad=%0d result=%h want 0/%h", seen, result, prev);
        end
    endtask

    task automatic test_reset_mid();
        int lat, scnt;
        logic [31:0] res, a, b;
        run_op(3'd0, 32'd7, 32'hFFFFFFFA, lat, res, scnt);
        checks++; if (res !== 32'hFFFFFFD6 || lat != 34) begin
            errors++; $display("FAIL rstmid_setup: got res=%h lat=%0d want ffffffd6/34", res, lat);
        end
        @(negedge clk);
        funct3 = 3'd1; op1 = $urandom; op2 = $urandom; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        #2; resetn = 1'b0; start = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++; $display("FAIL rstmid_async: stall=%b done=%b result=%h want 0/0/0", stall, done, result);
        end
        @(negedge clk); resetn = 1'b1; start = 1'b0;
        a = $urandom; b = 32'($urandom_range(1, 1000));
        run_op(3'd7, a, b, lat, res, scnt);
        checks++; if (lat != 34 || res !== ref_model(3'd7, a, b)) begin
            errors++; $display("FAIL rstmid_after: got res=%h lat=%0d want %h/34", res, lat, ref_model(3'd7, a, b));
        end
    endtask

    task automatic test_done_start();
        logic [31:0] a, b, got;
        int lat, seen;
        a = $urandom; b = $urandom;
        lat = -1; got = 32'd0;
        @(negedge clk);
        funct3 = 3'd3; op1 = a; op2 = b; start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (n > 0) begin @(negedge clk); start = 1'b0; end
            #1;
            if (done) begin lat = n; got = result; break; end
        end
        funct3 = 3'd4; op1 = 32'd5; op2 = 32'd0; start = 1'b1;
        #1;
        checks++; if (lat != 34 || got !== ref_model(3'd3, a, b)) begin
            errors++; $display("FAIL donestart_op: got res=%h lat=%0d want %h/34", got, lat, ref_model(3'd3, a, b));
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL donestart_stall: got %b want 0", stall); end
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            #1; if (done || stall) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0 || result !== got) begin
            errors++; $display("FAIL donestart_ignored: bad=%0d result=%h want 0/%h", seen, result, got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_done_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM. Sits beside the execute-stage ALU.
- Accepts operands after forwarding muxes (same sources the ALU sees) and runs a 32-step shift-add or restoring-divide loop.
- Holds the pipeline stalled until the result is ready, then presents the result for one cycle to the EX/MEM result mux.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- SPECIAL_FAST, 1, when 1, divide-by-zero and signed overflow complete without the iteration loop.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  issue request; sampled only in IDLE.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op1  input  XLEN  rs1 operand, already forwarded.
- op2  input  XLEN  rs2 operand, already forwarded.
- flush  input  1  abort the in-flight operation (branch mispredict or trap).
- stall  output  1  freeze IF/ID/EX pipeline registers.
- done  output  1  one-cycle result-valid pulse.
- result  output  XLEN  result; valid only while done=1.

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low; assertion forces state IDLE and clears done, result, counter and internal registers. stall is 0 during reset.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 latches funct3, op1 and op2.
  - Latches abs(op1) and abs(op2) per signedness: MUL/MULH/DIV/REM are signed/signed; MULHSU is signed/unsigned; MULHU/DIVU/REMU are unsigned. MUL takes the low word, so signedness is irrelevant.
  - Latches the result-negate flag: mul uses sign1 XOR sign2; div quotient uses sign1 XOR sign2; rem uses sign1.
  - Clears counter to 0 and goes to CALC.
- Special case, when SPECIAL_FAST=1 and a div/rem op is started:
  - op2==0: go directly to DONE with quotient 0xFFFFFFFF and remainder = op1, unmodified.
  - Signed DIV/REM with op1==0x80000000 and op2==0xFFFFFFFF: go to DONE with quotient 0x80000000 and remainder 0.
  - When SPECIAL_FAST=0, the loop still produces these values.
- CALC: one iteration per cycle; counter runs 0..31 and leaves to FIX after counter==31.
  - Multiply: 64-bit {hi,lo} shift-add.
  - Divide: restoring shift-subtract on a 33-bit partial remainder.
- FIX (1 cycle):
  - Apply the two's-complement negate when the flag is set.
  - Select the low word for MUL, the high word for MULH/MULHSU/MULHU, the quotient for DIV/DIVU, the remainder for REM/REMU.
  - Register the selection into result.
- DONE (1 cycle): done=1, result valid, stall=0. Next state is IDLE. A start in this cycle is ignored; the next instruction issues in the following IDLE cycle.
- stall:
  - Combinationally 1 in IDLE when start=1 and flush=0.
  - Registered 1 throughout CALC and FIX.
  - 0 in DONE and otherwise in IDLE.
- Latency: start in cycle T gives done in cycle T+34 (1 IDLE + 32 CALC + 1 FIX → DONE). Fast special cases give done in T+1.
- flush in any state: next state is IDLE, with no done pulse and no result update.
  - stall drops in the same cycle flush is seen; the combinational term is masked.
  - flush together with start in IDLE: the start is dropped.
- Inputs op1, op2 and funct3 may change after the start cycle without effect.
- result holds its last value outside DONE; consumers must qualify with done.

Test Plan:
- MUL 7 × 0xFFFFFFFA (−6) → done at T+34, result 0xFFFFFFD6; stall high T..T+33 and low at T+34.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF at T+1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, both at T+1.
- Start DIVU, assert flush at T+10 → IDLE at T+11, no done pulse, stall=0 from T+10; a new start at T+12 completes normally at T+46.
- Assert resetn=0 mid-CALC → stall, done and result all 0 immediately (asynchronous); a start after deassertion behaves normally. A start pulse during DONE is ignored.
